// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- registered execute-stage ALU with valid/ready handshakes.
//
// Accepts one operation per cycle when in_ready is high. The result is held in
// an output register until downstream consumes it. An internal NZCV flag
// register supplies carry-in to ADC/SBC. Flags are written only when set_flags
// is high.
//
// Optional feature: define ALU_PIPE_MUL_EN to add an iterative shift-add
// multiplier (command 4'b1010, MUL_BUSY state). Without the macro, 4'b1010 is
// treated as an undefined command.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   an operation is presented
//   in_ready   out  the block can accept an operation this cycle
//   exec_cmd   in   4-bit command code
//   val1/val2  in   WIDTH-bit operands
//   set_flags  in   update the flag register with this operation's flags
//   out_valid  out  alu_res holds an unconsumed result
//   out_ready  in   downstream consumes the result this cycle
//   alu_res    out  registered WIDTH-bit result
//   status     out  flag register {Z, C, N, V}
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exec_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  flags_t           flags_q, flags_d, op_flags;
  logic [WIDTH-1:0] res_q, res_d, op_res, b_op;
  logic [WIDTH:0]   sum;
  logic             out_valid_q, out_valid_d;
  logic             cin, arith, logic_op;
  logic             idle, accept, start_mul;

`ifdef ALU_PIPE_MUL_EN
  localparam int         CNT_W   = $clog2(WIDTH + 1);
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_s_q, mul_s_d;

  assign idle      = (state_q == IDLE);
  assign start_mul = accept && (exec_cmd == CMD_MUL);
`else
  assign idle      = 1'b1;
  assign start_mul = 1'b0;
`endif

  // in_ready depends on out_ready combinationally, so a full output register
  // drains and refills in the same cycle (throughput of one per cycle).
  assign in_ready  = idle && (!out_valid_q || out_ready) && !rst;
  assign accept    = in_valid && in_ready;

  assign alu_res   = res_q;
  assign out_valid = out_valid_q;
  assign status    = flags_q;

  // Single-cycle datapath. Subtraction is val1 + ~val2 + carry-in, so the
  // carry out of bit WIDTH means "no borrow" and one V formula serves both.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned -- otherwise synthesis would infer a latch.
    op_res   = '0;
    op_flags = flags_q;
    b_op     = val2;
    cin      = 1'b0;
    arith    = 1'b0;
    logic_op = 1'b0;
    case (exec_cmd)
      CMD_MOV: begin op_res = val2;        logic_op = 1'b1; end
      CMD_MVN: begin op_res = ~val2;       logic_op = 1'b1; end
      CMD_AND: begin op_res = val1 & val2; logic_op = 1'b1; end
      CMD_ORR: begin op_res = val1 | val2; logic_op = 1'b1; end
      CMD_EOR: begin op_res = val1 ^ val2; logic_op = 1'b1; end
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = flags_q.c; end
      CMD_SUB: begin arith = 1'b1; b_op = ~val2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; b_op = ~val2; cin = flags_q.c; end
      default: ;
    endcase
    sum = {1'b0, val1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      op_res     = sum[WIDTH-1:0];
      op_flags.c = sum[WIDTH];
      op_flags.v = (val1[WIDTH-1] == b_op[WIDTH-1]) &&
                   (op_res[WIDTH-1] != val1[WIDTH-1]);
    end
    if (arith || logic_op) begin
      op_flags.n = op_res[WIDTH-1];
      op_flags.z = (op_res == '0);
    end
  end

  // Next-state logic for the output register, flags and multiplier FSM.
  always_comb begin
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
`ifdef ALU_PIPE_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_s_d  = mul_s_q;
`endif
    if (accept && !start_mul) begin
      res_d       = op_res;
      out_valid_d = 1'b1;
      if (set_flags) flags_d = op_flags;
    end
`ifdef ALU_PIPE_MUL_EN
    if (start_mul) begin
      mcand_d  = val1;
      mplier_d = val2;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
      mul_s_d  = set_flags;
      state_d  = MUL_BUSY;
    end
    if (state_q == MUL_BUSY) begin
      // One extra cycle at count zero writes the result: WIDTH+1 edges total.
      if (cnt_q == '0) begin
        res_d       = acc_q;
        out_valid_d = 1'b1;
        if (mul_s_q) begin
          flags_d.n = acc_q[WIDTH-1];
          flags_d.z = (acc_q == '0);
        end
        state_d = IDLE;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
      end
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_s_q     <= 1'b0;
`endif
    end else begin
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_s_q     <= mul_s_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH = 32).
// Expected results come from a behavioural model evaluated at the accept
// edge and queued; a monitor pops and compares on each consumed result.
// Multiplier scenarios run only when ALU_PIPE_MUL_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   st;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   exec_cmd;
  logic [W-1:0] val1;
  logic [W-1:0] val2;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_res;
  logic [3:0]   status;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exec_cmd  (exec_cmd),
    .val1      (val1),
    .val2      (val2),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_res   (alu_res),
    .status    (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: flags {Z,C,N,V}, subtraction via true difference.
  exp_t       sb[$];
  logic [3:0] m_flags;

  task automatic model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output exp_t e);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         z, c, n, v, c_new, v_new, nz_upd, cv_upd;
    {z, c, n, v} = m_flags;
    r = '0; res = '0; c_new = 1'b0; v_new = 1'b0; nz_upd = 1'b0; cv_upd = 1'b0;
    case (cmd)
      4'b0001: begin res = b;     nz_upd = 1'b1; end
      4'b1001: begin res = ~b;    nz_upd = 1'b1; end
      4'b0110: begin res = a & b; nz_upd = 1'b1; end
      4'b0111: begin res = a | b; nz_upd = 1'b1; end
      4'b1000: begin res = a ^ b; nz_upd = 1'b1; end
      4'b0010, 4'b0011: begin
        r = {1'b0, a} + {1'b0, b} + ((cmd == 4'b0011) ? {{W{1'b0}}, c} : '0);
        res = r[W-1:0]; c_new = r[W];
        v_new = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        nz_upd = 1'b1; cv_upd = 1'b1;
      end
      4'b0100, 4'b0101: begin
        r = {1'b0, a} - {1'b0, b} - ((cmd == 4'b0101) ? {{W{1'b0}}, ~c} : '0);
        res = r[W-1:0]; c_new = ~r[W];
        v_new = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        nz_upd = 1'b1; cv_upd = 1'b1;
      end
`ifdef ALU_PIPE_MUL_EN
      4'b1010: begin res = a * b; nz_upd = 1'b1; end
`endif
      default: res = '0;
    endcase
    if (s && nz_upd) begin
      n = res[W-1];
      z = (res == '0);
      if (cv_upd) begin c = c_new; v = v_new; end
    end
    m_flags = {z, c, n, v};
    e.res = res;
    e.st  = m_flags;
  endtask

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s);
    exp_t e;
    int   k;
    in_valid = 1'b1; exec_cmd = cmd; val1 = a; val2 = b; set_flags = s;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    if (k >= 200) begin
      check("accept_timeout", k, 0);
      in_valid = 1'b0;
      return;
    end
    model(cmd, a, b, s, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor / scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_unexpected_output", 0, 1);
      else begin
        mon_e = sb.pop_front();
        check("res", alu_res, mon_e.res);
        check("status", status, mon_e.st);
      end
    end
  end

  // Random backpressure while enabled.
  bit bp_en = 1'b0;
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0] cmd_tbl [11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                               4'b0110, 4'b0111, 4'b1000, 4'b0000, 4'b1111};
  exp_t e_hold;
  int   c0, c1, k;
  bit   flag;

  initial begin
    rst = 1'b1; in_valid = 1'b0; exec_cmd = '0; val1 = '0; val2 = '0;
    set_flags = 1'b0; out_ready = 1'b1; m_flags = '0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_alu_res", alu_res, 0);
    check("rst_status", status, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Carry-out and zero from ADD.
    send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("add_valid_1cyc", out_valid, 1);
    check("add_res", alu_res, 32'h0000_0000);
    check("add_status", status, 4'b1100);

    // Signed overflow, then ADC back-to-back consumes the new C.
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    check("ovf_res", alu_res, 32'h8000_0000);
    check("ovf_status", status, 4'b0011);
    send(4'b0011, 32'h0, 32'h0, 1'b1);
    check("adc_res", alu_res, 32'h0);
    check("adc_status", status, 4'b1000);

    // Borrow, then SBC with C=0.
    send(4'b0100, 32'd5, 32'd7, 1'b1);
    check("sub_res", alu_res, 32'hFFFF_FFFE);
    check("sub_status", status, 4'b0010);
    send(4'b0101, 32'd5, 32'd3, 1'b1);
    check("sbc_res", alu_res, 32'h0000_0001);
    check("sbc_status", status, 4'b0100);

    // set_flags=0 leaves flags alone; undefined codes give 0 with flags held.
    send(4'b0010, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("nos_status", status, 4'b0100);
    send(4'b0000, 32'h1234, 32'h5678, 1'b1);
    check("undef0_res", alu_res, 0);
    check("undef0_status", status, 4'b0100);
    send(4'b1111, 32'h1234, 32'h5678, 1'b1);
    check("undef15_res", alu_res, 0);
`ifndef ALU_PIPE_MUL_EN
    send(4'b1010, 32'd3, 32'd4, 1'b1);
    check("mul_off_valid", out_valid, 1);
    check("mul_off_res", alu_res, 0);
    check("mul_off_status", status, 4'b0100);
`endif

    // Random mix, second half under random backpressure.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      if (i == 20) bp_en = 1'b1;
      send(cmd_tbl[$urandom_range(0, 10)], a, b, 1'($urandom_range(0, 1)));
    end
    bp_en = 1'b0;
    @(posedge clk); #2; out_ready = 1'b1;
    @(posedge clk); #1;

    // Output full: in_ready low, result and flags hold.
    send(4'b1000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
    out_ready = 1'b0;
    e_hold = sb[sb.size()-1];
    in_valid = 1'b1; exec_cmd = 4'b0010; val1 = 32'd1; val2 = 32'd2; set_flags = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_res", alu_res, e_hold.res);
      check("stall_status", status, e_hold.st);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    c0 = cyc;
    send(4'b0010, 32'd1, 32'd2, 1'b1);
    send(4'b0100, 32'd2, 32'd9, 1'b1);
    send(4'b0101, 32'd100, 32'd1, 1'b1);
    send(4'b0110, 32'hFF00, 32'h0FF0, 1'b1);
    send(4'b1001, 32'd0, 32'd0, 1'b1);
    send(4'b0001, 32'd0, 32'hDEAD_BEEF, 1'b1);
    c1 = cyc;
    check("throughput_cycles", c1 - c0, 6);

`ifdef ALU_PIPE_MUL_EN
    // MUL latency and in_ready during MUL_BUSY.
    send(4'b1010, 32'h0001_0001, 32'h0000_0003, 1'b1);
    k = 0; flag = 1'b0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1; k++;
      if (!out_valid && in_ready) flag = 1'b1;
    end
    check("mul_latency", k, 33);
    check("mul_busy_ready", flag, 0);
    check("mul_res", alu_res, 32'h0003_0003);
    send(4'b1010, 32'hDEAD_BEEF, 32'h1234_5677, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
    check("mul2_latency", k, 33);

    // Reset on cycle 10 of a MUL aborts it.
    send(4'b0100, 32'd5, 32'd7, 1'b1);
    send(4'b1010, 32'h1234_5678, 32'd9, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1; sb.delete(); m_flags = '0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_status", status, 0);
    flag = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) flag = 1'b1; end
    check("abort_no_valid", flag, 0);
    @(posedge clk); #1;
`endif

    k = 0;
    while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the execute-stage ALU. Accepts one operation per cycle over a valid/ready handshake, holds the result in an output register with its own handshake, and keeps an internal NZCV flag register that supplies carry-in to ADC/SBC. An optional iterative shift-add multiplier adds a multi-cycle MUL command. The block sits between the ID/EX pipeline register and the EX/MEM stage; its stall signal is `in_ready`.

## Interface
- `WIDTH`, 32: operand/result width (≥ 8)
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block can accept an operation this cycle
- `exec_cmd`  in  4  command code (see Operation)
- `val1`, `val2`  in  WIDTH  operands
- `set_flags`  in  1  ARM S bit; flag register updated only when 1
- `out_valid`  out  1  `alu_res` holds an unconsumed result
- `out_ready`  in  1  downstream consumes the result
- `alu_res`  out  WIDTH  registered result
- `status`  out  4  flag register {Z, C, N, V}

## Operation
- Commands: 0001 MOV (val2), 1001 MVN (~val2), 0010 ADD, 0011 ADC (val1+val2+C), 0100 SUB, 0101 SBC (val1−val2−!C), 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL (macro only). All other codes: result 0, flags unchanged, single-cycle.
- Arithmetic is WIDTH+1 bits wide; C = bit WIDTH of the sum. SUB/SBC computed as val1 + ~val2 + (1 or C), so C = 1 means no borrow.
- V (add): val1[W-1] == val2[W-1] and res[W-1] != val1[W-1]. V (sub): val1[W-1] != val2[W-1] and res[W-1] != val1[W-1].
- N = res[W-1]; Z = (res == 0).
- Logical ops and MOV/MVN update N, Z only; C, V hold.
- `set_flags` = 0: flag register untouched for any command.
- States: IDLE, MUL_BUSY.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready) && !rst.
- Accept = `in_valid && in_ready`. Single-cycle command: result and flags written at the accept edge, `out_valid` set.
- Accept of MUL: latch operands, zero accumulator, counter = WIDTH, go MUL_BUSY. Each cycle: if multiplier LSB set, add multiplicand; shift multiplicand left, multiplier right; decrement counter. At counter 0: write low WIDTH bits to `alu_res`, set `out_valid`, update N, Z (if S), return to IDLE.
- `out_valid` clears on `out_ready` when no new result is written at the same edge; if consume and new accept coincide, `out_valid` stays 1 with the new result.
- `in_valid` without acceptance: inputs ignored; the source must hold them.

## Timing
- Reset values: `alu_res` 0, `status` 4'b0000, `out_valid` 0, state IDLE, counter 0; `in_ready` 0 while `rst` is high.
- Single-cycle latency: accept at edge N, result valid after edge N; throughput 1/cycle with `out_ready` held high.
- MUL latency: WIDTH+1 edges from accept to `out_valid`; `in_ready` low throughout MUL_BUSY.
- Back-to-back ADC/SBC uses the C written by the previous accept at that same edge (no forwarding hazard).
- Output full (`out_valid` 1, `out_ready` 0): `in_ready` low; result and flags hold.
- Reset mid-MUL aborts: IDLE, no result, flags cleared.

## Configuration
- `ALU_PIPE_MUL_EN` defined: MUL command and MUL_BUSY state present.
- Not defined: no multiplier logic, state machine reduces to IDLE only; 1010 treated as an undefined command (result 0, single-cycle, flags held).

## Test plan
- Reset, then ADD 0xFFFFFFFF + 0x00000001, S=1 -> `alu_res` 0x00000000, `status` {Z,C,N,V} = 1100, 1 cycle later.
- ADD 0x7FFFFFFF + 1 (S=1) then ADC 0 + 0 back-to-back -> first 0x80000000, status 0011; second 0x00000000 with C=0, status 1000.
- SUB 5 − 7, S=1 -> 0xFFFFFFFE, status 0010; SBC 5 − 3 next with C=0 -> 0x00000001.
- `out_ready` low for 3 cycles with `in_valid` high -> `in_ready` low, `alu_res` and `status` stable; release -> one result consumed per cycle.
- MUL (macro on) 0x00010001 × 0x00000003, S=1 -> 0x00030003 after 33 edges, `in_ready` low meanwhile, status N=0, Z=0, C/V unchanged.
- `rst` asserted on cycle 10 of a MUL -> no `out_valid`, `status` 0000, `in_ready` 1 the cycle after `rst` drops.
